vgc_regs: RTL and testbench

CPU-side register and interrupt block for the video graphics controller. It decodes $C0xx I/O accesses and holds the video configuration registers and soft switches that drive the VGC. It also latches the VGC's scanline and VBL interrupt strobes plus an internal one-second tick into acknowledgeable status bits, and combines them into a single active-low CPU IRQ.

---
 rtl/vgc_regs_pkg.sv | 43 ++++
 rtl/vgc_irq_latch.sv | 25 ++
 rtl/vgc_regs.sv | 147 ++++++++++++++
 tb/tb_vgc_regs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vgc_regs_pkg.sv
// Address map, reset values and field positions for the VGC CPU register block.
package vgc_regs_pkg;

   localparam logic [7:0] ADDR_RDVBLBAR  = 8'h19;
   localparam logic [7:0] ADDR_TEXTCOLOR = 8'h22;
   localparam logic [7:0] ADDR_VGCINT    = 8'h23;
   localparam logic [7:0] ADDR_NEWVIDEO  = 8'h29;
   localparam logic [7:0] ADDR_INTCLR    = 8'h32;
   localparam logic [7:0] ADDR_BORDER    = 8'h34;
   localparam logic [7:0] ADDR_INTEN     = 8'h41;
   localparam logic [7:0] ADDR_VBLSTAT   = 8'h46;
   localparam logic [7:0] ADDR_VBLCLR    = 8'h47;

   // Switch pairs: even address clears, odd address sets.
   localparam logic [7:0] ADDR_80COL_SW   = 8'h0C;
   localparam logic [7:0] ADDR_ALTCHAR_SW = 8'h0E;
   localparam logic [7:0] ADDR_TEXTG_SW   = 8'h50;
   localparam logic [7:0] ADDR_MIXG_SW    = 8'h52;
   localparam logic [7:0] ADDR_PAGE2_SW   = 8'h54;
   localparam logic [7:0] ADDR_HIRES_SW   = 8'h56;

   localparam logic [7:0] ADDR_ST_TEXTG   = 8'h1A;
   localparam logic [7:0] ADDR_ST_MIXG    = 8'h1B;
   localparam logic [7:0] ADDR_ST_PAGE2   = 8'h1C;
   localparam logic [7:0] ADDR_ST_HIRES   = 8'h1D;
   localparam logic [7:0] ADDR_ST_ALTCHAR = 8'h1E;
   localparam logic [7:0] ADDR_ST_80COL   = 8'h1F;

   localparam logic [7:0] RST_NEWVIDEO  = 8'h01;
   localparam logic [7:0] RST_TEXTCOLOR = 8'hF6;
   localparam logic [7:0] RST_BORDER    = 8'h06;

   localparam int VGCINT_EN_SCAN = 1;
   localparam int VGCINT_EN_SEC  = 2;
   localparam int CLR_SCAN_BIT   = 5;
   localparam int CLR_SEC_BIT    = 6;
   localparam int INTEN_VBL      = 3;

   function automatic logic [7:0] stat_byte(input logic b);
      return {b, 7'b0};
   endfunction

endpackage

// File: rtl/vgc_irq_latch.sv
// Rising-edge interrupt status flop; a set and a clear in the same cycle keeps the set.
module vgc_irq_latch (
   input  logic CLK_14M,
   input  logic reset_n,
   input  logic evt,
   input  logic clr,
   output logic stat
);

   logic evt_prev;

   always_ff @(posedge CLK_14M) begin
      if (!reset_n) begin
         evt_prev <= 1'b0;
         stat     <= 1'b0;
      end else begin
         evt_prev <= evt;
         if (evt && !evt_prev)
            stat <= 1'b1;
         else if (clr)
            stat <= 1'b0;
      end
   end

endmodule

// File: rtl/vgc_regs.sv
// $C0xx register, soft-switch and interrupt block for the VGC.
// VGC_ONESEC_EN builds the one-second tick counter and its status bit.
module vgc_regs
   import vgc_regs_pkg::*;
#(
   parameter int ONESEC_DIV = 14318180,
   parameter int VBL_START  = 208
) (
   input  logic       CLK_14M,
   input  logic       reset_n,
   input  logic       cpu_ce,
   input  logic [7:0] addr,
   input  logic       we,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic [8:0] V,
   input  logic       scanline_irq,
   input  logic       vbl_irq,
   output logic       irq_n,
   output logic [7:0] NEWVIDEO,
   output logic [7:0] TEXTCOLOR,
   output logic [3:0] BORDERCOLOR,
   output logic       TEXTG,
   output logic       MIXG,
   output logic       PAGE2,
   output logic       HIRES_MODE,
   output logic       EIGHTYCOL,
   output logic       ALTCHARSET
);

   localparam logic [8:0] VBL_LINE = 9'(VBL_START);

   // Bus: cpu_ce marks exactly one cycle per CPU I/O access, addr/we/din are
   // sampled only on that cycle; read data answers one cycle later for one cycle.
   logic [7:0] border_q;
   logic [7:0] inten_q;
   logic [1:0] en_q;
   logic       scan_stat, sec_stat, vbl_stat;
   logic       scan_clr, vbl_clr, any_int;
   logic [7:0] rd_data;
   logic       rd_hit;

   assign BORDERCOLOR = border_q[3:0];
   assign scan_clr    = cpu_ce & we & (addr == ADDR_INTCLR) & ~din[CLR_SCAN_BIT];
   assign vbl_clr     = cpu_ce & (addr == ADDR_VBLCLR);
   assign any_int     = (scan_stat & en_q[VGCINT_EN_SCAN-1]) | (sec_stat & en_q[VGCINT_EN_SEC-1]);

   vgc_irq_latch u_scan (.CLK_14M(CLK_14M), .reset_n(reset_n), .evt(scanline_irq),
                         .clr(scan_clr), .stat(scan_stat));
   vgc_irq_latch u_vbl  (.CLK_14M(CLK_14M), .reset_n(reset_n), .evt(vbl_irq),
                         .clr(vbl_clr), .stat(vbl_stat));

`ifdef VGC_ONESEC_EN
   localparam int CNT_W = (ONESEC_DIV > 1) ? $clog2(ONESEC_DIV) : 1;
   logic [CNT_W-1:0] sec_cnt;
   logic             sec_tick, sec_clr;

   assign sec_tick = (sec_cnt == CNT_W'(ONESEC_DIV - 1));
   assign sec_clr  = cpu_ce & we & (addr == ADDR_INTCLR) & ~din[CLR_SEC_BIT];

   always_ff @(posedge CLK_14M) begin
      if (!reset_n)
         sec_cnt <= '0;
      else if (sec_tick)
         sec_cnt <= '0;
      else
         sec_cnt <= sec_cnt + CNT_W'(1);
   end

   vgc_irq_latch u_sec (.CLK_14M(CLK_14M), .reset_n(reset_n), .evt(sec_tick),
                        .clr(sec_clr), .stat(sec_stat));
`else
   // No counter: the one-second status can never set.
   assign sec_stat = (ONESEC_DIV <= 0);
`endif

   always_ff @(posedge CLK_14M) begin
      if (!reset_n) begin
         NEWVIDEO   <= RST_NEWVIDEO;
         TEXTCOLOR  <= RST_TEXTCOLOR;
         border_q   <= RST_BORDER;
         inten_q    <= 8'h00;
         en_q       <= 2'b00;
         TEXTG      <= 1'b1;
         MIXG       <= 1'b0;
         PAGE2      <= 1'b0;
         HIRES_MODE <= 1'b0;
         EIGHTYCOL  <= 1'b0;
         ALTCHARSET <= 1'b0;
      end else if (cpu_ce) begin
         if (we) begin
            case (addr)
               ADDR_NEWVIDEO:  NEWVIDEO  <= din;
               ADDR_TEXTCOLOR: TEXTCOLOR <= din;
               ADDR_BORDER:    border_q  <= din;
               ADDR_VGCINT:    en_q      <= din[VGCINT_EN_SEC:VGCINT_EN_SCAN];
               ADDR_INTEN:     inten_q   <= din;
               default: ;
            endcase
            if (addr[7:1] == ADDR_80COL_SW[7:1])   EIGHTYCOL  <= addr[0];
            if (addr[7:1] == ADDR_ALTCHAR_SW[7:1]) ALTCHARSET <= addr[0];
         end
         case (addr[7:1])
            ADDR_TEXTG_SW[7:1]: TEXTG      <= addr[0];
            ADDR_MIXG_SW[7:1]:  MIXG       <= addr[0];
            ADDR_PAGE2_SW[7:1]: PAGE2      <= addr[0];
            ADDR_HIRES_SW[7:1]: HIRES_MODE <= addr[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_hit  = 1'b1;
      rd_data = 8'h00;
      case (addr)
         ADDR_NEWVIDEO:   rd_data = NEWVIDEO;
         ADDR_TEXTCOLOR:  rd_data = TEXTCOLOR;
         ADDR_BORDER:     rd_data = border_q;
         ADDR_VGCINT:     rd_data = {any_int, sec_stat, scan_stat, 2'b00, en_q, 1'b0};
         ADDR_INTEN:      rd_data = inten_q;
         ADDR_VBLSTAT:    rd_data[INTEN_VBL] = vbl_stat;
         ADDR_RDVBLBAR:   rd_data = stat_byte(V >= VBL_LINE);
         ADDR_ST_TEXTG:   rd_data = stat_byte(TEXTG);
         ADDR_ST_MIXG:    rd_data = stat_byte(MIXG);
         ADDR_ST_PAGE2:   rd_data = stat_byte(PAGE2);
         ADDR_ST_HIRES:   rd_data = stat_byte(HIRES_MODE);
         ADDR_ST_ALTCHAR: rd_data = stat_byte(ALTCHARSET);
         ADDR_ST_80COL:   rd_data = stat_byte(EIGHTYCOL);
         default:         rd_hit  = 1'b0;
      endcase
   end

   always_ff @(posedge CLK_14M) begin
      if (!reset_n) begin
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         irq_n      <= 1'b1;
      end else begin
         dout       <= (cpu_ce && !we && rd_hit) ? rd_data : 8'h00;
         dout_valid <= cpu_ce & ~we & rd_hit;
         irq_n      <= ~(any_int | (vbl_stat & inten_q[INTEN_VBL]));
      end
   end

endmodule

// File: tb/tb_vgc_regs.sv
// Table-driven bench for vgc_regs with a read-data scoreboard and hand-written
// interrupt sequences; the one-second checks follow VGC_ONESEC_EN.
module tb_vgc_regs;

   logic       CLK_14M = 1'b0;
   logic       reset_n = 1'b0;
   logic       cpu_ce = 1'b0;
   logic [7:0] addr = 8'h00;
   logic       we = 1'b0;
   logic [7:0] din = 8'h00;
   logic [8:0] V = 9'd100;
   logic       scanline_irq = 1'b0;
   logic       vbl_irq = 1'b0;
   logic [7:0] dout, NEWVIDEO, TEXTCOLOR;
   logic [3:0] BORDERCOLOR;
   logic       dout_valid, irq_n;
   logic       TEXTG, MIXG, PAGE2, HIRES_MODE, EIGHTYCOL, ALTCHARSET;

   vgc_regs #(.ONESEC_DIV(100), .VBL_START(208)) dut (
      .CLK_14M(CLK_14M), .reset_n(reset_n), .cpu_ce(cpu_ce), .addr(addr), .we(we),
      .din(din), .dout(dout), .dout_valid(dout_valid), .V(V),
      .scanline_irq(scanline_irq), .vbl_irq(vbl_irq), .irq_n(irq_n),
      .NEWVIDEO(NEWVIDEO), .TEXTCOLOR(TEXTCOLOR), .BORDERCOLOR(BORDERCOLOR),
      .TEXTG(TEXTG), .MIXG(MIXG), .PAGE2(PAGE2), .HIRES_MODE(HIRES_MODE),
      .EIGHTYCOL(EIGHTYCOL), .ALTCHARSET(ALTCHARSET)
   );

   // clock / reset
   always #5 CLK_14M = ~CLK_14M;

`ifdef VGC_ONESEC_EN
   localparam logic SEC_IRQ_EXP_N = 1'b0;
`else
   localparam logic SEC_IRQ_EXP_N = 1'b1;
`endif

   typedef struct packed {
      logic [7:0] a;
      logic       w;
      logic [7:0] d;
      logic [8:0] v;
      logic       chk;
      logic [8:0] exp;
      logic [7:0] mask;
   } vec_t;

   vec_t       tbl[$];
   logic [8:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic tick();
      @(posedge CLK_14M);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver + scoreboard: expected {valid, data} queued at drive, popped at response
   task automatic bus(input logic [7:0] a, input logic w, input logic [7:0] d,
                      input logic chk, input logic [8:0] exp, input logic [7:0] mask,
                      input string name);
      logic [8:0] e;
      cpu_ce = 1'b1; addr = a; we = w; din = d;
      if (chk) exp_q.push_back(exp);
      tick();
      cpu_ce = 1'b0; we = 1'b0;
      if (chk) begin
         if (exp_q.size() == 0) begin
            check({name, "_queue"}, 16'(0), 16'(1));
         end else begin
            e = exp_q.pop_front();
            check({name, "_valid"}, 16'(dout_valid), 16'(e[8]));
            check({name, "_data"}, 16'(dout & mask), 16'(e[7:0] & mask));
         end
      end
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic [7:0] mask,
                     input string name);
      bus(a, 1'b0, 8'h00, 1'b1, {1'b1, exp}, mask, name);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus(a, 1'b1, d, 1'b0, 9'h000, 8'hFF, "wr");
   endtask

   function automatic void add(logic [7:0] a, logic w, logic [7:0] d, logic [8:0] v,
                               logic chk, logic [8:0] exp, logic [7:0] mask);
      vec_t t;
      t.a = a; t.w = w; t.d = d; t.v = v; t.chk = chk; t.exp = exp; t.mask = mask;
      tbl.push_back(t);
   endfunction

   initial begin
      add(8'h29, 0, 8'h00, 9'd100, 1, 9'h101, 8'hFF);
      add(8'h22, 0, 8'h00, 9'd100, 1, 9'h1F6, 8'hFF);
      add(8'h34, 0, 8'h00, 9'd100, 1, 9'h106, 8'hFF);
      add(8'h23, 0, 8'h00, 9'd100, 1, 9'h100, 8'hBF);
      add(8'h41, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h46, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h1A, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h1B, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'hFF, 0, 8'h00, 9'd100, 1, 9'h000, 8'hFF);
      add(8'h29, 1, 8'h55, 9'd100, 1, 9'h000, 8'hFF);
      add(8'h29, 0, 8'h00, 9'd100, 1, 9'h155, 8'hFF);
      add(8'h34, 1, 8'hA9, 9'd100, 1, 9'h000, 8'hFF);
      add(8'h34, 0, 8'h00, 9'd100, 1, 9'h1A9, 8'hFF);
      add(8'h22, 1, 8'h3C, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h22, 0, 8'h00, 9'd100, 1, 9'h13C, 8'hFF);
      add(8'h41, 1, 8'hF7, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h41, 0, 8'h00, 9'd100, 1, 9'h1F7, 8'hFF);
      add(8'h41, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h55, 0, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1C, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h54, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1C, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h0D, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1F, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h0C, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h0D, 0, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1F, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h0F, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1E, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h50, 0, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1A, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h53, 1, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1B, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h57, 0, 8'h00, 9'd100, 0, 9'h000, 8'hFF);
      add(8'h1D, 0, 8'h00, 9'd100, 1, 9'h180, 8'hFF);
      add(8'h19, 0, 8'h00, 9'd210, 1, 9'h180, 8'hFF);
      add(8'h19, 0, 8'h00, 9'd100, 1, 9'h100, 8'hFF);
      add(8'h19, 0, 8'h00, 9'd208, 1, 9'h180, 8'hFF);
      add(8'h19, 0, 8'h00, 9'd207, 1, 9'h100, 8'hFF);

      // reset state
      repeat (3) tick();
      reset_n = 1'b1;
      check("rst_irq_n", 16'(irq_n), 16'(1));
      check("rst_textg", 16'(TEXTG), 16'(1));
      check("rst_newvideo", 16'(NEWVIDEO), 16'h01);
      check("rst_dout", 16'({dout_valid, dout}), 16'h000);
      check("rst_page2", 16'(PAGE2), 16'(0));

      // one-second tick: first counted edge carries the enable write
      wr(8'h23, 8'h04);
      for (int i = 2; i <= 100; i++) tick();
      check("sec_early", 16'(irq_n), 16'(1));
      tick();
      check("sec_irq", 16'(irq_n), 16'(SEC_IRQ_EXP_N));
      wr(8'h23, 8'h00);
      wr(8'h32, 8'h00);
      tick();
      check("sec_cleared", 16'(irq_n), 16'(1));

      // register / switch table
      for (int i = 0; i < tbl.size(); i++) begin
         V = tbl[i].v;
         bus(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].chk, tbl[i].exp, tbl[i].mask,
             $sformatf("vec%0d_%02h", i, tbl[i].a));
      end
      V = 9'd100;
      check("out_border", 16'(BORDERCOLOR), 16'h9);
      check("out_textcolor", 16'(TEXTCOLOR), 16'h3C);
      check("out_newvideo", 16'(NEWVIDEO), 16'h55);
      check("out_switches", 16'({TEXTG, MIXG, PAGE2, HIRES_MODE, EIGHTYCOL, ALTCHARSET}),
            16'b010101);

      // scanline: held high, latency, clear without re-set
      wr(8'h23, 8'h02);
      scanline_irq = 1'b1;
      tick();
      check("scan_lag", 16'(irq_n), 16'(1));
      tick();
      check("scan_irq", 16'(irq_n), 16'(0));
      rd(8'h23, 8'hA2, 8'hBF, "scan_vgcint");
      tick();
      check("dout_one_cycle", 16'(dout_valid), 16'(0));
      wr(8'h32, 8'h00);
      tick();
      check("scan_clr", 16'(irq_n), 16'(1));
      repeat (10) tick();
      check("scan_no_reset", 16'(irq_n), 16'(1));
      rd(8'h23, 8'h02, 8'hBF, "scan_after_clr");
      scanline_irq = 1'b0;
      repeat (2) tick();

      // rising edge coincident with a clearing write: set wins
      scanline_irq = 1'b1;
      wr(8'h32, 8'h00);
      rd(8'h23, 8'hA2, 8'hBF, "scan_set_wins");
      scanline_irq = 1'b0;
      wr(8'h32, 8'h20);
      rd(8'h23, 8'hA2, 8'hBF, "scan_keep_bit5");
      wr(8'h32, 8'h00);
      tick();
      check("scan_clr2", 16'(irq_n), 16'(1));
      wr(8'h23, 8'h00);

      // VBL status, enable and clear
      wr(8'h41, 8'h08);
      vbl_irq = 1'b1;
      tick();
      vbl_irq = 1'b0;
      tick();
      check("vbl_irq", 16'(irq_n), 16'(0));
      rd(8'h46, 8'h08, 8'hFF, "vbl_stat");
      bus(8'h47, 1'b0, 8'h00, 1'b0, 9'h000, 8'hFF, "vbl_ack");
      rd(8'h46, 8'h00, 8'hFF, "vbl_acked");
      check("vbl_irq_clr", 16'(irq_n), 16'(1));
      wr(8'h41, 8'h00);
      vbl_irq = 1'b1;
      tick();
      vbl_irq = 1'b0;
      tick();
      check("vbl_masked", 16'(irq_n), 16'(1));
      rd(8'h46, 8'h08, 8'hFF, "vbl_stat_masked");
      wr(8'h41, 8'h08);
      tick();
      check("vbl_enable", 16'(irq_n), 16'(0));

      // reset mid-operation
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mid_rst_irq_n", 16'(irq_n), 16'(1));
      check("mid_rst_regs", 16'({NEWVIDEO, TEXTCOLOR}), 16'h01F6);
      check("mid_rst_sw", 16'({BORDERCOLOR, TEXTG, MIXG, PAGE2, HIRES_MODE, EIGHTYCOL,
                                 ALTCHARSET}), 16'b0110_100000);
      rd(8'h46, 8'h00, 8'hFF, "mid_rst_vbl");
      rd(8'h41, 8'h00, 8'hFF, "mid_rst_inten");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
